pc_seq_ctrl: RTL and testbench

//   Sequences the program-counter register of the pipeline CPU. It generates the

---
 rtl/pc_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencing for the pipelined CPU: stall/write-enable for the
// PC register, next-PC selection, and IF/ID flush and ID/EX bubble requests.
module pc_seq_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h00400004,
   parameter int          MD_MAX     = 64,
   parameter int          CNT_W      = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   input  logic        load_use,
   input  logic        md_start,
   input  logic        md_done,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret,
   output logic        pc_stall,
   output logic        pc_wena,
   output logic [31:0] pc_next,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic [31:0] epc,
   output logic        md_timeout
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MD_WAIT  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] md_cnt;

   logic md_hold;
   logic md_go;
   logic lu_go;
   logic md_last;

   assign md_hold = (state == MD_WAIT) && !md_done;
   assign md_go   = (state != MD_WAIT) && md_start;
   assign lu_go   = (state == RUN) && load_use;
   assign md_last = (md_cnt == CNT_W'(MD_MAX - 1));

   // NOTE: every output gets a stalled default first so no path can infer a latch.
   always_comb begin
      pc_stall     = 1'b1;
      pc_wena      = 1'b0;
      pc_next      = pc_cur;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      if (rst) begin
         pc_stall = 1'b1;
      end else if (exc_req) begin
         pc_stall     = 1'b0;
         pc_wena      = 1'b1;
         pc_next      = EXC_VECTOR;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (eret) begin
         pc_stall    = 1'b0;
         pc_wena     = 1'b1;
         pc_next     = epc;
         if_id_flush = 1'b1;
      end else if (md_hold || md_go || lu_go) begin
         id_ex_bubble = 1'b1;
      end else if (br_taken) begin
         pc_stall    = 1'b0;
         pc_wena     = 1'b1;
         pc_next     = br_target;
         if_id_flush = 1'b1;
      end else begin
         pc_stall = 1'b0;
         pc_wena  = 1'b1;
         pc_next  = pc_cur + 32'd4;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         md_cnt     <= '0;
         epc        <= 32'h0;
         md_timeout <= 1'b0;
      end else begin
         md_timeout <= 1'b0;
         if (exc_req) begin
            epc    <= pc_cur;
            state  <= RUN;
            md_cnt <= '0;
         end else if (eret) begin
            state  <= RUN;
            md_cnt <= '0;
         end else begin
            case (state)
               MD_WAIT: begin
                  if (md_done) begin
                     state  <= RUN;
                     md_cnt <= '0;
                  end else if (md_last) begin
                     md_timeout <= 1'b1;
                     state      <= RUN;
                     md_cnt     <= '0;
                  end else begin
                     md_cnt <= md_cnt + 1'b1;
                  end
               end
               default: begin
                  // LU_STALL lands here too; lu_go is false there, so it cannot re-stall.
                  if (md_go) begin
                     state  <= MD_WAIT;
                     md_cnt <= '0;
                  end else if (lu_go) begin
                     state <= LU_STALL;
                  end else begin
                     state <= RUN;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: reset, sequential/wrap, load-use, mul/div
// release and timeout, branch vs exception priority, exception/ERET, reset abort.
module tb_pc_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_cur;
   logic        load_use;
   logic        md_start;
   logic        md_done;
   logic        br_taken;
   logic [31:0] br_target;
   logic        exc_req;
   logic        eret;
   logic        pc_stall;
   logic        pc_wena;
   logic [31:0] pc_next;
   logic        if_id_flush;
   logic        id_ex_bubble;
   logic [31:0] epc;
   logic        md_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_seq_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .pc_cur       (pc_cur),
      .load_use     (load_use),
      .md_start     (md_start),
      .md_done      (md_done),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .exc_req      (exc_req),
      .eret         (eret),
      .pc_stall     (pc_stall),
      .pc_wena      (pc_wena),
      .pc_next      (pc_next),
      .if_id_flush  (if_id_flush),
      .id_ex_bubble (id_ex_bubble),
      .epc          (epc),
      .md_timeout   (md_timeout)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      load_use  = 1'b0;
      md_start  = 1'b0;
      md_done   = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'h0;
      exc_req   = 1'b0;
      eret      = 1'b0;
   endtask

   initial begin
      int stall_cnt;
      int tmo_cnt;

      idle();
      rst    = 1'b1;
      pc_cur = 32'h00400000;

      // reset holds the PC
      tick();
      #1;
      check("rst_stall", pc_stall, 1);
      check("rst_wena", pc_wena, 0);
      check("rst_next", pc_next, 32'h00400000);
      check("rst_flush", if_id_flush, 0);
      tick();
      check("rst_epc", epc, 32'h0);
      check("rst_tmo", md_timeout, 0);
      rst = 1'b0;

      // sequential and wrap
      #1;
      check("seq_next", pc_next, 32'h00400004);
      check("seq_wena", pc_wena, 1);
      check("seq_stall", pc_stall, 0);
      check("seq_flush", if_id_flush, 0);
      pc_cur = 32'hFFFFFFFC;
      #1;
      check("wrap_next", pc_next, 32'h00000000);

      // load-use: one stall cycle, then released even with load_use still high
      tick();
      pc_cur   = 32'h00400008;
      load_use = 1'b1;
      #1;
      check("lu_stall", pc_stall, 1);
      check("lu_bubble", id_ex_bubble, 1);
      check("lu_wena", pc_wena, 0);
      check("lu_next", pc_next, 32'h00400008);
      tick();
      #1;
      check("lu_rel_stall", pc_stall, 0);
      check("lu_rel_wena", pc_wena, 1);
      check("lu_rel_next", pc_next, 32'h0040000C);
      tick();
      load_use = 1'b0;
      pc_cur   = 32'h0040000C;
      #1;
      check("lu_after_next", pc_next, 32'h00400010);

      // mul/div released by md_done after 5 stalled cycles
      tick();
      md_start  = 1'b1;
      stall_cnt = 0;
      #1;
      if (pc_stall && id_ex_bubble && !pc_wena) stall_cnt++;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         if (pc_stall && id_ex_bubble && !pc_wena) stall_cnt++;
      end
      check("md_stall_cycles", stall_cnt, 5);
      tick();
      md_done = 1'b1;
      #1;
      check("md_rel_stall", pc_stall, 0);
      check("md_rel_wena", pc_wena, 1);
      check("md_rel_next", pc_next, 32'h00400010);
      tick();
      md_start = 1'b0;
      md_done  = 1'b0;
      #1;
      check("md_run_wena", pc_wena, 1);
      check("md_no_tmo", md_timeout, 0);

      // mul/div timeout: start cycle plus MD_MAX waiting cycles
      md_start  = 1'b1;
      stall_cnt = 0;
      tmo_cnt   = 0;
      #1;
      if (pc_stall) stall_cnt++;
      tick();
      md_start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (pc_stall) stall_cnt++;
         if (md_timeout) tmo_cnt++;
         tick();
      end
      check("tmo_stall_cycles", stall_cnt, 65);
      check("tmo_early", tmo_cnt, 0);
      check("tmo_pulse", md_timeout, 1);
      check("tmo_run_wena", pc_wena, 1);
      tick();
      check("tmo_one_cycle", md_timeout, 0);

      // branch, then branch overridden by exception
      pc_cur    = 32'h00400050;
      br_taken  = 1'b1;
      br_target = 32'h00400100;
      #1;
      check("br_next", pc_next, 32'h00400100);
      check("br_flush", if_id_flush, 1);
      check("br_wena", pc_wena, 1);
      exc_req = 1'b1;
      #1;
      check("exc_over_br", pc_next, 32'h00400004);
      check("exc_bubble", id_ex_bubble, 1);
      tick();
      idle();
      check("exc_epc_br", epc, 32'h00400050);

      // exception during MD_WAIT, then ERET
      pc_cur   = 32'h00400020;
      md_start = 1'b1;
      tick();
      md_start = 1'b0;
      tick();
      exc_req = 1'b1;
      #1;
      check("exc_md_next", pc_next, 32'h00400004);
      check("exc_md_stall", pc_stall, 0);
      tick();
      exc_req = 1'b0;
      #1;
      check("exc_md_epc", epc, 32'h00400020);
      check("exc_md_run", pc_next, 32'h00400024);
      pc_cur = 32'h00400004;
      eret   = 1'b1;
      #1;
      check("eret_next", pc_next, 32'h00400020);
      check("eret_flush", if_id_flush, 1);
      check("eret_wena", pc_wena, 1);
      tick();
      eret = 1'b0;

      // reset aborts a mul/div wait
      md_start = 1'b1;
      tick();
      md_start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("rst_md_stall", pc_stall, 1);
      check("rst_md_wena", pc_wena, 0);
      tick();
      rst = 1'b0;
      #1;
      check("rst_md_run", pc_wena, 1);
      check("rst_md_epc", epc, 32'h0);
      tmo_cnt = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (md_timeout) tmo_cnt++;
      end
      check("rst_md_no_tmo", tmo_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
